// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the register file: merges ALU and load write-backs into an
// in-order FIFO, drains one write per cycle, and forwards still-queued data to operand reads.
module regfile_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_addr,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    output logic                   rf_wr,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_din,
    input  logic [AW-1:0]          raddr1,
    input  logic [AW-1:0]          raddr2,
    input  logic [DW-1:0]          rf_dout1,
    input  logic [DW-1:0]          rf_dout2,
    output logic [DW-1:0]          op1,
    output logic [DW-1:0]          op2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          alu_push, mem_push, pop;
    logic [PW-1:0] mem_slot;
    entry_t        head;

    // Ready looks only at registered occupancy so it never depends on the same-cycle pop.
    assign alu_ready = (count_q < DEPTH_C);
    assign mem_ready = alu_valid ? (count_q < DEPTH_M1) : (count_q < DEPTH_C);

    assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
    assign mem_push = mem_valid && mem_ready && (mem_addr != '0);
    assign pop      = (count_q != '0);
    assign mem_slot = wr_ptr_q + PW'(alu_push);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(alu_push) + PW'(mem_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (alu_push) fifo_q[wr_ptr_q] <= '{addr: alu_addr, data: alu_data};
        if (mem_push) fifo_q[mem_slot] <= '{addr: mem_addr, data: mem_data};
    end

    assign head     = fifo_q[rd_ptr_q];
    assign rf_wr    = pop;
    assign rf_waddr = pop ? head.addr : '0;
    assign rf_din   = pop ? head.data : '0;

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Walk oldest to youngest so the youngest matching entry overrides older ones.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op1 = rf_dout1;
        op2 = rf_dout2;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (fifo_q[rd_ptr_q + PW'(i)].addr == raddr1) op1 = fifo_q[rd_ptr_q + PW'(i)].data;
                if (fifo_q[rd_ptr_q + PW'(i)].addr == raddr2) op2 = fifo_q[rd_ptr_q + PW'(i)].data;
            end
        end
        if (raddr1 == '0) op1 = '0;
        if (raddr2 == '0) op2 = '0;
    end
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Scoreboard bench for regfile_wb_buffer: stimulus pushes expected regfile writes,
// a negedge monitor pops and compares them whenever rf_wr is presented.
module tb_regfile_wb_buffer;
    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        rf_wr;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_din;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rf_dout1, rf_dout2;
    logic [31:0] op1, op2;
    logic [2:0]  count;
    logic        full, empty;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   model_cnt = 0;

    regfile_wb_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_din(rf_din),
        .raddr1(raddr1), .raddr2(raddr2), .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
        .op1(op1), .op2(op2), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Monitor: every presented write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rf_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rf_wr without pending write", 64'(rf_wr), 64'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                check("rf_din", 64'(rf_din), 64'(e.data));
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
        bit exp_ar, exp_mr;
        int pushes;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        @(negedge clk);
        exp_ar = (model_cnt < 4);
        exp_mr = av ? (model_cnt < 3) : (model_cnt < 4);
        check("alu_ready", 64'(alu_ready), 64'(exp_ar));
        check("mem_ready", 64'(mem_ready), 64'(exp_mr));
        check("count", 64'(count), 64'(model_cnt));
        check("full", 64'(full), 64'(model_cnt == 4));
        check("empty", 64'(empty), 64'(model_cnt == 0));
        pushes = 0;
        if (av && exp_ar && aa != 5'd0) begin exp_q.push_back('{aa, ad}); pushes++; end
        if (mv && exp_mr && ma != 5'd0) begin exp_q.push_back('{ma, md}); pushes++; end
        model_cnt = model_cnt + pushes - ((model_cnt > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic fwd1(input string name, input logic [4:0] a, input logic [31:0] dout, input logic [31:0] exp);
        raddr1 = a; rf_dout1 = dout;
        #1;
        check(name, 64'(op1), 64'(exp));
    endtask

    task automatic fwd2(input string name, input logic [4:0] a, input logic [31:0] dout, input logic [31:0] exp);
        raddr2 = a; rf_dout2 = dout;
        #1;
        check(name, 64'(op2), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        raddr1 = 0; raddr2 = 0; rf_dout1 = 0; rf_dout2 = 0;
        #2;
        check("reset count", 64'(count), 64'd0);
        check("reset empty", 64'(empty), 64'd1);
        check("reset full", 64'(full), 64'd0);
        check("reset rf_wr", 64'(rf_wr), 64'd0);
        check("reset rf_waddr", 64'(rf_waddr), 64'd0);
        check("reset rf_din", 64'(rf_din), 64'd0);
        check("reset alu_ready", 64'(alu_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write: accepted at edge 1, on the write port in cycle 2, gone after edge 2.
        cyc(1, 5'd5, 32'h0000_00AA, 0, 5'd0, 32'd0);
        check("single rf_wr", 64'(rf_wr), 64'd1);
        check("single rf_waddr", 64'(rf_waddr), 64'd5);
        check("single rf_din", 64'(rf_din), 64'hAA);
        fwd1("single head forwards", 5'd5, 32'h1234, 32'hAA);
        idle(1);
        check("single empty after drain", 64'(empty), 64'd1);
        fwd1("single from regfile", 5'd5, 32'h1234, 32'h1234);

        // Register 0 is handshaken but never queued.
        cyc(1, 5'd0, 32'h0000_DEAD, 0, 5'd0, 32'd0);
        check("r0 count unchanged", 64'(count), 64'd0);
        check("r0 no write", 64'(rf_wr), 64'd0);
        fwd1("r0 reads zero", 5'd0, 32'h5555_5555, 32'd0);

        // Simultaneous accept to the same register: ALU older, load younger.
        cyc(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        check("simul count", 64'(count), 64'd2);
        fwd1("simul youngest wins", 5'd3, 32'h99, 32'h22);
        idle(1);
        fwd1("simul after first pop", 5'd3, 32'h99, 32'h22);
        idle(1);
        fwd1("simul from regfile", 5'd3, 32'h99, 32'h99);

        // Back-pressure: both producers held, drain active; occupancy saturates at DEPTH-1.
        cyc(1, 5'd6, 32'h600, 1, 5'd7, 32'h700);
        cyc(1, 5'd8, 32'h800, 1, 5'd9, 32'h900);
        cyc(1, 5'd10, 32'hA00, 1, 5'd11, 32'hB00);
        cyc(1, 5'd12, 32'hC00, 1, 5'd13, 32'hD00);
        for (int i = 0; i < 20; i++) begin
            bit av, mv;
            av = ($urandom_range(0, 3) != 0);
            mv = ($urandom_range(0, 3) != 0);
            cyc(av, 5'($urandom_range(0, 7)), $urandom, mv, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(5);

        // Wrap-around: ten single pushes, pointers circle the 4-entry FIFO twice.
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'd0);
            fwd2("wrap pending fwd", 5'(i), 32'hFFFF_FFFF, 32'h100 + 32'(i));
            fwd2("wrap other reg", 5'(i + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        end
        idle(2);

        // Reset mid-cycle with three entries queued: queued writes are discarded.
        cyc(1, 5'd20, 32'h2020, 1, 5'd21, 32'h2121);
        cyc(1, 5'd22, 32'h2222, 1, 5'd23, 32'h2323);
        check("pre-reset count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("mid reset count", 64'(count), 64'd0);
        check("mid reset empty", 64'(empty), 64'd1);
        check("mid reset rf_wr", 64'(rf_wr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 10 && model_cnt > 0; i++) idle(1);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
